// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide request path: request codes,
// the queued entry layout and a small classification helper.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // op, rs operand, rt operand
  localparam int MD_ENTRY_W = 67;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  // True for requests that start a multi-cycle multiply or divide
  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO. A push while full is dropped even
// if a pop happens in the same cycle, so a full queue never accepts data.
module md_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 67
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_COUNT) && !reset;
  assign do_pop  = pop && (count != '0) && !reset;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/md_req_queue.sv
// In-order request buffer in front of the multiply/divide unit. Requests are
// issued from the head whenever the unit is idle; mfhi/mflo stall until all
// older HI/LO writers have been issued and the unit has finished.
module md_req_queue
  import md_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        mf_req,
  input  logic        md_busy,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_if_mthi,
  output logic        md_if_mtlo,
  output logic        stall,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  md_entry_t              wr_entry;
  md_entry_t              head;
  logic [MD_ENTRY_W-1:0]  head_bits;
  logic                   has_entry;
  logic                   push;
  logic                   pop;

  assign wr_entry  = '{op: req_op, a: req_a, b: req_b};
  assign head      = md_entry_t'(head_bits);
  assign has_entry = (count != '0);
  assign req_ready = (count != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign pop       = has_entry && !md_busy && !reset;

  md_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (MD_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_bits),
    .count (count)
  );

  // Issue strobes from the head entry; illegal codes pop silently as NOPs
  always_comb begin
    md_start   = 1'b0;
    md_if_mthi = 1'b0;
    md_if_mtlo = 1'b0;
    md_op      = 2'b00;
    md_a       = '0;
    md_b       = '0;
    if (has_entry) begin
      md_op = head.op[1:0];
      md_a  = head.a;
      md_b  = head.b;
    end
    if (pop) begin
      md_start   = is_md_arith(head.op);
      md_if_mthi = (head.op == MD_MTHI);
      md_if_mtlo = (head.op == MD_MTLO);
    end
  end

  // Stall on a full-queue push or on mfhi/mflo behind pending HI/LO writers
  always_comb begin
    stall = (req_valid && !req_ready) || (mf_req && (has_entry || md_busy));
  end

endmodule

// File: doc/md_req_queue.md
Name: md_req_queue

Overview:
- Upstream feeder for the E-stage multiply/divide unit (ports clk, reset, A, B, op[1:0], start, if_mthi, if_mtlo, Busy).
- Buffers up to DEPTH mult/multu/div/divu/mthi/mtlo requests from the pipeline so back-to-back MD instructions do not stall issue.
- Drains the requests in order whenever the MD unit is idle.
- Generates the stall for mfhi/mflo until every older HI/LO writer has completed.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- AW, 2, pointer width, log2(DEPTH)

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  reset; synchronous, active-high; same signal drives the MD unit.
- req_valid  in  1  pipeline presents an MD request this cycle.
- req_op  in  3  request code (package enum).
- req_a  in  32  rs operand.
- req_b  in  32  rt operand.
- req_ready  out  1  queue can accept; high iff count < DEPTH.
- mf_req  in  1  mfhi/mflo in the consuming stage this cycle.
- md_busy  in  1  Busy from the MD unit.
- md_start  out  1  to MD unit start.
- md_op  out  2  to MD unit op (head req_op[1:0]).
- md_a  out  32  to MD unit A.
- md_b  out  32  to MD unit B.
- md_if_mthi  out  1  to MD unit if_mthi.
- md_if_mtlo  out  1  to MD unit if_mtlo.
- stall  out  1  pipeline stall request.
- count  out  AW+1  current occupancy.

Behaviour:
- State: DEPTH-entry array {op[2:0], a[31:0], b[31:0]}, rd_ptr and wr_ptr (AW bits, natural wrap DEPTH-1 -> 0), count.
- Reset: rd_ptr = 0, wr_ptr = 0, count = 0. All outputs then read md_start = 0, md_if_mthi = 0, md_if_mtlo = 0, md_a = 0, md_b = 0, md_op = 0, stall = 0, req_ready = 1.
- Reset mid-operation discards all queued entries; no partial issue.
- push = req_valid && req_ready. The entry is written at wr_ptr on the clock edge.
- pop = (count != 0) && !md_busy.
- Issue outputs are combinational from the head entry, gated by pop:
  - md_start = pop && op in {MULT, MULTU, DIV, DIVU}.
  - md_if_mthi = pop && op == MTHI.
  - md_if_mtlo = pop && op == MTLO.
  - md_op = head op[1:0].
  - md_a = head a and md_b = head b when count != 0, else 0.
- At most one entry is issued per cycle, so start and mthi/mtlo are never simultaneous.
- Latency: a request pushed at edge t is issuable at cycle t+1 at the earliest (no bypass).
- The MD unit raises Busy on the edge after start. md_busy is therefore already high in the following cycle, and no extra guard is needed.
- mthi/mtlo are never issued while md_busy = 1 (the MD unit would ignore them). They wait in order behind the running op.
- Illegal op codes 6 and 7 are accepted, then popped with no md_* strobe (treated as NOP).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: req_ready = 0 even if a pop occurs the same cycle (no pop-through).
- Empty: no pop, all strobes 0.
- stall = (req_valid && !req_ready) || (mf_req && (count != 0 || md_busy)).
- mf_req with an empty queue and idle unit does not stall. HI/LO are valid that cycle, because the MD unit writes HI/LO on the same edge it clears Busy.
- mf_req and req_valid in the same cycle are mutually exclusive by decode. If both are asserted anyway, the stall term above still applies unchanged.
- count never exceeds DEPTH; pointers never need explicit compare-wrap logic.

Decomposition:
- Package md_pkg:
  - localparams MD_MULT = 3'd0, MD_MULTU = 3'd1, MD_DIV = 3'd2, MD_DIVU = 3'd3, MD_MTHI = 3'd4, MD_MTLO = 3'd5.
  - Predicate function is_md_arith(op).
  - Entry width constant MD_ENTRY_W = 67.
- Decoder (instruction -> req_op) lives in the D-stage controller, not here.
- One natural sub-module: md_fifo (generic DEPTH x WIDTH synchronous FIFO with push/pop/count, no pop-through). md_req_queue wraps it with the issue gating and stall logic.

Test Plan:
- Reset then idle -> count = 0, req_ready = 1, all md_* = 0, stall = 0; reset asserted with 3 entries queued -> count = 0 next cycle, no strobes.
- Push MULT a = 0xFFFFFFFE, b = 3 at t, md_busy = 0 -> md_start = 1, md_op = 0, md_a = 0xFFFFFFFE, md_b = 3 at t+1; count back to 0 at t+2.
- Busy model held high 5 cycles; push DIV then MTHI a = 0x1234 -> MTHI strobe (md_if_mthi = 1, md_a = 0x1234) appears only after DIV issued and md_busy returned low, never while busy.
- Push 4 entries with md_busy = 1 -> count = 4, req_ready = 0; 5th req_valid -> stall = 1 and entry not stored. Drop busy -> order preserved and pointer wraps 3 -> 0 correctly.
- mf_req = 1 with count = 1 -> stall = 1; with count = 0, md_busy = 1 -> stall = 1; with count = 0, md_busy = 0 -> stall = 0.
- Simultaneous push and pop at count = 2 -> count stays 2; push op = 7 -> popped later with md_start, md_if_mthi, md_if_mtlo all 0.
